unpremuat1_32_buf: RTL

- Streaming 32-point reorder buffer on the transform datapath.
- Undoes the 32-point even/odd interleave or de-interleave applied ahead of the butterfly stages. Each row must be rebuilt in natural order before quantisation or reconstruction.
- Accepts a row as 32/LANES beats of LANES coefficients and emits the un-permuted row in the same beat format.
- Ping-pong banks sustain one beat per cycle.

---
 rtl/unpremuat1_32_buf_pkg.sv | 43 ++++
 rtl/unpremuat1_32_buf_bank.sv | 52 +++++
 rtl/unpremuat1_32_buf.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/unpremuat1_32_buf_pkg.sv
// Shared definitions for the 32-point reorder buffer.
// Mode enum and the y[k] <- x[src] index map.
package tq_perm_pkg;

  localparam int ROW_LEN   = 32;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    PASS           = 2'd0,
    UNINTERLEAVE   = 2'd1,
    UNDEINTERLEAVE = 2'd2
  } perm_mode_t;

  function automatic perm_mode_t mode_sel(
    input logic en,
    input logic inv
  );
    perm_mode_t m;
    m = PASS;
    unique case (1'b1)
      !en:        m = PASS;
      en && !inv: m = UNINTERLEAVE;
      default:    m = UNDEINTERLEAVE;
    endcase
    return m;
  endfunction

  // Both permutations are 5-bit rotations of k.
  function automatic logic [4:0] src_idx(
    input perm_mode_t mode,
    input logic [4:0] k
  );
    logic [4:0] r;
    r = k;
    case (mode)
      UNINTERLEAVE:   r = {k[3:0], k[4]};
      UNDEINTERLEAVE: r = {k[0], k[4:1]};
      default:        r = k;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/unpremuat1_32_buf_bank.sv
// One 32-entry row bank with latched mode.
// Beat-wide write port, permuting beat-wide read mux.
module unpremuat_bank
  import tq_perm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = 8,
  parameter int CW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               we,
  input  logic               mode_we,
  input  perm_mode_t         mode_in,
  input  logic [CW-1:0]      widx,
  input  logic [LANES*WIDTH-1:0] wdata,
  input  logic [CW-1:0]      ridx,
  output logic [LANES*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ROW_LEN];
  perm_mode_t mode;

  // Row storage and mode captured with beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROW_LEN; i++)
        mem[i] <= '0;
      mode <= PASS;
    end else if (clear) begin
      for (int i = 0; i < ROW_LEN; i++)
        mem[i] <= '0;
      mode <= PASS;
    end else if (we) begin
      for (int j = 0; j < LANES; j++)
        mem[5'(int'(widx) * LANES + j)] <=
          wdata[j*WIDTH +: WIDTH];
      if (mode_we)
        mode <= mode_in;
    end
  end

  // Gather output lanes through the index map.
  always_comb begin
    rdata = '0;
    for (int j = 0; j < LANES; j++)
      rdata[j*WIDTH +: WIDTH] =
        mem[src_idx(mode, 5'(int'(ridx) * LANES + j))];
  end

endmodule

// File: rtl/unpremuat1_32_buf.sv
// Ping-pong 32-point un-permute buffer.
// Optional row counter: UNPERM_ROWCNT_EN.
module unpremuat1_32_buf
  import tq_perm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               inverse_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic               out_last
`ifdef UNPERM_ROWCNT_EN
  ,
  output logic [15:0]        rows_done_o
`endif
);

  localparam int BEATS = ROW_LEN / LANES;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic          wr_bank;
  logic          rd_bank;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [1:0]    full;
  logic [1:0]    full_nxt;

  logic wr_fire;
  logic rd_fire;
  logic wr_end;
  logic rd_end;
  logic mode_we;
  logic we0;
  logic we1;

  perm_mode_t mode_in;

  logic [LANES*WIDTH-1:0] rdata0;
  logic [LANES*WIDTH-1:0] rdata1;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_end    = wr_fire && (wr_cnt == LAST);
  assign rd_end    = rd_fire && (rd_cnt == LAST);
  assign out_last  = out_valid && (rd_cnt == LAST);
  assign out_data  = rd_bank ? rdata1 : rdata0;
  assign mode_in   = mode_sel(en_i, inverse_i);
  assign mode_we   = (wr_cnt == '0);
  assign we0       = wr_fire && !wr_bank;
  assign we1       = wr_fire && wr_bank;

  unpremuat_bank #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .CW    (CW)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_i),
    .we      (we0),
    .mode_we (mode_we),
    .mode_in (mode_in),
    .widx    (wr_cnt),
    .wdata   (in_data),
    .ridx    (rd_cnt),
    .rdata   (rdata0)
  );

  unpremuat_bank #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .CW    (CW)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_i),
    .we      (we1),
    .mode_we (mode_we),
    .mode_in (mode_in),
    .widx    (wr_cnt),
    .wdata   (in_data),
    .ridx    (rd_cnt),
    .rdata   (rdata1)
  );

  // Fill flags: writer sets its bank, reader clears its own.
  always_comb begin
    full_nxt = full;
    if (wr_end)
      full_nxt[wr_bank] = 1'b1;
    if (rd_end)
      full_nxt[rd_bank] = 1'b0;
  end

  // Bank-full flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      full <= '0;
    else if (clear_i)
      full <= '0;
    else
      full <= full_nxt;
  end

  // Write beat counter and bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (clear_i) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      if (wr_end) begin
        wr_cnt  <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // Read beat counter and bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (clear_i) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      if (rd_end) begin
        rd_cnt  <= '0;
        rd_bank <= !rd_bank;
      end else begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

`ifdef UNPERM_ROWCNT_EN
  // Rows delivered downstream, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rows_done_o <= '0;
    else if (clear_i)
      rows_done_o <= '0;
    else if (rd_end)
      rows_done_o <= rows_done_o + 16'd1;
  end
`endif

endmodule
